// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-detects peripheral events, masks and
// prioritises them, and holds a single IRQ to the CPU until it is taken and acknowledged.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no enabled request outstanding, or waiting for one to appear
//   REQ     | enabled pending source exists, IRQ exposed unless in kernel mode
//   SERVICE | handler running; further requests held off until EOI write

module irq_controller #(
    parameter int          NSRC      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h40000020
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            PC_31,
    input  logic            irq_taken,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [31:0]     Address,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    output logic            IRQ
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [31:0] MASK_ADDR  = BASE_ADDR;
    localparam logic [31:0] PEND_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0] CAUSE_ADDR = BASE_ADDR + 32'd8;
    localparam logic [31:0] EOI_ADDR   = BASE_ADDR + 32'd12;

    state_t          state;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] src_d;
    logic [4:0]      cause_id;
    logic            in_service;

    logic            sel_mask;
    logic            sel_pend;
    logic            sel_cause;
    logic            sel_eoi;
    logic            wr_mask;
    logic            wr_pend;
    logic            wr_eoi;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] enabled;
    logic            active;
    logic [4:0]      winner;
    logic [NSRC-1:0] win_onehot;
    logic            claim;
    logic [NSRC-1:0] pending_clr;
    logic [NSRC-1:0] pending_nxt;

    // Upper write-data bits beyond NSRC have no destination.
    logic            unused_wdata;
    assign unused_wdata = ^WriteData;

    assign sel_mask  = (Address == MASK_ADDR);
    assign sel_pend  = (Address == PEND_ADDR);
    assign sel_cause = (Address == CAUSE_ADDR);
    assign sel_eoi   = (Address == EOI_ADDR);

    assign wr_mask = MemWrite & sel_mask;
    assign wr_pend = MemWrite & sel_pend;
    assign wr_eoi  = MemWrite & sel_eoi;

    assign rise    = irq_src & ~src_d;
    assign enabled = pending & mask;
    assign active  = |enabled;

    // Descending scan so the lowest enabled index is the one left standing.
    always_comb begin
        winner     = '0;
        win_onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                winner        = 5'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign claim = (state == REQ) & active & irq_taken;

    // A new event wins over any clear landing on the same bit in the same cycle.
    assign pending_clr = (wr_pend ? WriteData[NSRC-1:0] : '0) | (claim ? win_onehot : '0);
    assign pending_nxt = (pending & ~pending_clr) | rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            mask       <= '0;
            pending    <= '0;
            src_d      <= '0;
            cause_id   <= '0;
            in_service <= 1'b0;
        end else begin
            src_d   <= irq_src;
            pending <= pending_nxt;
            if (wr_mask) begin
                mask <= WriteData[NSRC-1:0];
            end
            case (state)
                IDLE: begin
                    if (active) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (irq_taken) begin
                        cause_id   <= winner;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (sel_mask) begin
                ReadData[NSRC-1:0] = mask;
            end else if (sel_pend) begin
                ReadData[NSRC-1:0] = pending;
            end else if (sel_cause) begin
                ReadData[31]  = in_service;
                ReadData[4:0] = cause_id;
            end
        end
    end

    // Combinational from registered state so leaving kernel mode re-exposes the request.
    assign IRQ = (state == REQ) & ~PC_31;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed walk through the main scenarios, then randomized
// traffic compared cycle by cycle against a behavioural model of the controller.

module tb_irq_controller;

    localparam int          NSRC    = 4;
    localparam logic [31:0] BASE    = 32'h40000020;
    localparam logic [31:0] A_MASK  = BASE;
    localparam logic [31:0] A_PEND  = BASE + 32'd4;
    localparam logic [31:0] A_CAUSE = BASE + 32'd8;
    localparam logic [31:0] A_EOI   = BASE + 32'd12;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_SVC  = 2;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic            PC_31;
    logic            irq_taken;
    logic            MemRead;
    logic            MemWrite;
    logic [31:0]     Address;
    logic [31:0]     WriteData;
    logic [31:0]     ReadData;
    logic            IRQ;

    irq_controller #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .PC_31     (PC_31),
        .irq_taken (irq_taken),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .IRQ       (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the controller's architectural state
    logic [NSRC-1:0] m_mask  = '0;
    logic [NSRC-1:0] m_pend  = '0;
    logic [NSRC-1:0] m_srcd  = '0;
    logic [4:0]      m_cause = '0;
    logic            m_insvc = 1'b0;
    int              m_state = S_IDLE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == A_MASK)  return 32'(m_mask);
        if (a == A_PEND)  return 32'(m_pend);
        if (a == A_CAUSE) return {m_insvc, 26'd0, m_cause};
        return 32'd0;
    endfunction

    task automatic model_edge();
        logic [NSRC-1:0] rise;
        logic [NSRC-1:0] en;
        logic [NSRC-1:0] clr;
        int              win;
        if (!reset) begin
            m_mask  = '0;
            m_pend  = '0;
            m_srcd  = '0;
            m_cause = '0;
            m_insvc = 1'b0;
            m_state = S_IDLE;
            return;
        end
        rise = irq_src & ~m_srcd;
        en   = m_pend & m_mask;
        win  = -1;
        for (int i = 0; i < NSRC; i++) begin
            if (en[i] && win < 0) win = i;
        end
        clr = '0;
        if (MemWrite && Address == A_PEND) clr = WriteData[NSRC-1:0];
        if (m_state == S_IDLE) begin
            if (win >= 0) m_state = S_REQ;
        end else if (m_state == S_REQ) begin
            if (win < 0) begin
                m_state = S_IDLE;
            end else if (irq_taken) begin
                clr[win] = 1'b1;
                m_cause  = 5'(win);
                m_insvc  = 1'b1;
                m_state  = S_SVC;
            end
        end else begin
            if (MemWrite && Address == A_EOI) begin
                m_insvc = 1'b0;
                m_state = S_IDLE;
            end
        end
        m_pend = (m_pend & ~clr) | rise;
        if (MemWrite && Address == A_MASK) m_mask = WriteData[NSRC-1:0];
        m_srcd = irq_src;
    endtask

    task automatic check_out(input string tag);
        #1;
        check_val({tag, "_irq"}, 32'(IRQ), 32'(m_state == S_REQ && !PC_31));
        check_val({tag, "_rd"}, ReadData, MemRead ? model_read(Address) : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        irq_taken = 1'b0;
        check_out("tick");
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        Address   = a;
        WriteData = d;
        tick();
    endtask

    task automatic read_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1;
        Address = a;
        #1;
        check_val(tag, ReadData, exp);
        MemRead = 1'b0;
    endtask

    task automatic irq_exp(input string tag, input logic exp);
        #1;
        check_val(tag, 32'(IRQ), 32'(exp));
    endtask

    logic [31:0] rnd_addrs [7];

    initial begin
        rnd_addrs = '{A_MASK, A_PEND, A_CAUSE, A_EOI, BASE + 32'd16, BASE + 32'd2, BASE - 32'd4};
        reset     = 1'b0;
        irq_src   = '0;
        PC_31     = 1'b0;
        irq_taken = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b1;
        read_exp("rst_mask", A_MASK, 32'd0);
        read_exp("rst_pend", A_PEND, 32'd0);
        read_exp("rst_cause", A_CAUSE, 32'd0);
        irq_exp("rst_irq", 1'b0);

        // Single source request, kernel-mode suppression
        bus_write(A_MASK, 32'h2);
        irq_src = 4'b0010;
        tick();
        irq_src = '0;
        read_exp("s1_pend", A_PEND, 32'h2);
        irq_exp("s1_irq_k", 1'b0);
        tick();
        irq_exp("s1_irq_k1", 1'b1);
        PC_31 = 1'b1;
        irq_exp("s1_kernel", 1'b0);
        PC_31 = 1'b0;
        irq_exp("s1_user", 1'b1);

        // Take and acknowledge
        irq_taken = 1'b1;
        tick();
        read_exp("s2_cause", A_CAUSE, 32'h80000001);
        read_exp("s2_pend", A_PEND, 32'h0);
        irq_exp("s2_irq", 1'b0);
        bus_write(A_EOI, 32'h0);
        read_exp("s2_cause_eoi", A_CAUSE, 32'h00000001);
        tick();
        irq_exp("s2_irq_eoi", 1'b0);

        // Priority between simultaneous events
        bus_write(A_MASK, 32'hF);
        irq_src = 4'b1010;
        tick();
        irq_src = '0;
        tick();
        irq_exp("s3_irq", 1'b1);
        irq_taken = 1'b1;
        tick();
        read_exp("s3_cause1", A_CAUSE, 32'h80000001);
        read_exp("s3_pend1", A_PEND, 32'h8);
        bus_write(A_EOI, 32'h0);
        irq_exp("s3_irq_e", 1'b0);
        tick();
        irq_exp("s3_irq_e1", 1'b1);
        irq_taken = 1'b1;
        tick();
        read_exp("s3_cause3", A_CAUSE, 32'h80000003);
        bus_write(A_EOI, 32'h0);

        // Masked event, late enable, then W1C withdraw
        bus_write(A_MASK, 32'h0);
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        read_exp("s4_pend", A_PEND, 32'h4);
        tick();
        irq_exp("s4_irq_masked", 1'b0);
        bus_write(A_MASK, 32'h4);
        irq_exp("s4_irq_e1", 1'b0);
        tick();
        irq_exp("s4_irq_e2", 1'b1);
        bus_write(A_PEND, 32'h4);
        tick();
        irq_exp("s4_irq_w1c", 1'b0);
        read_exp("s4_pend_w1c", A_PEND, 32'h0);

        // Event coincident with its own W1C; unmapped reads
        irq_src = 4'b0001;
        bus_write(A_PEND, 32'h1);
        irq_src = '0;
        read_exp("s5_pend_keep", A_PEND, 32'h1);
        read_exp("s5_unmapped", BASE + 32'd16, 32'h0);
        read_exp("s5_eoi_rd", A_EOI, 32'h0);

        // Reset in SERVICE with pending work, then stray take in IDLE
        bus_write(A_MASK, 32'hF);
        tick();
        irq_taken = 1'b1;
        tick();
        irq_src = 4'b0110;
        tick();
        irq_src = '0;
        read_exp("s6_pend", A_PEND, 32'h6);
        read_exp("s6_cause", A_CAUSE, 32'h80000000);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        read_exp("s6_rst_mask", A_MASK, 32'h0);
        read_exp("s6_rst_pend", A_PEND, 32'h0);
        read_exp("s6_rst_cause", A_CAUSE, 32'h0);
        irq_exp("s6_rst_irq", 1'b0);
        irq_taken = 1'b1;
        tick();
        read_exp("s6_stray_cause", A_CAUSE, 32'h0);
        irq_exp("s6_stray_irq", 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int op;
            reset = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < NSRC; b++) begin
                if ($urandom_range(0, 3) == 0) irq_src[b] = ~irq_src[b];
            end
            PC_31     = ($urandom_range(0, 3) == 0);
            irq_taken = (m_state == S_REQ) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            op        = $urandom_range(0, 9);
            Address   = rnd_addrs[$urandom_range(0, 6)];
            WriteData = $urandom();
            if (op == 0) begin
                MemWrite = 1'b1;
                Address  = A_MASK;
            end else if (op == 1) begin
                MemWrite = 1'b1;
                Address  = A_PEND;
            end else if (op == 2 || (m_state == S_SVC && op == 3)) begin
                MemWrite = 1'b1;
                Address  = A_EOI;
            end
            MemRead = ($urandom_range(0, 1) == 1);
            check_out("rnd");
            tick();
        end
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
